shots_pool: RTL
===============

// Module: shots_pool
// PURPOSE
//  Manages a fixed pool of player projectiles: spawns a shot on a fire press, moves every
//  live shot up the screen once per frame and retires it at the top edge or on a hit.
//  Per pixel it produces shotsDrawingRequest/shotsRGB for the objects priority mux,
//  which sits directly downstream. Collision detection lives elsewhere and feeds back a hit pulse.
// PARAMETERS
//  NUM_SHOTS        4      pool size (slots 0..NUM_SHOTS-1)
//  SHOT_W           4      shot width in pixels
//  SHOT_H           8      shot height in pixels
//  SPEED            4      pixels moved upward per frame
//  SPAWN_X_OFFSET   14     added to playerX to give the spawn x
//  COOLDOWN_FRAMES  8      frames after an accepted fire before the next fire is accepted
//  SHOT_RGB         8'hFC  RRRGGGBB colour of a shot pixel
// PORTS
//  clk                  in   1          system clock
//  reset                in   1          asynchronous, active-high reset
//  startOfFrame         in   1          one-cycle pulse, once per frame
//  fire                 in   1          fire key level (edge-detected internally)
//  playerX, playerY     in   11 each    player top-left
//  pixelX, pixelY       in   11 each    current scan pixel
//  collision            in   1          hit on the shot drawn in the previous cycle's output
//  shotsDrawingRequest  out  1          current output pixel belongs to a shot
//  shotsRGB             out  8          SHOT_RGB when requesting, else 8'hFF
//  shotsActive          out  NUM_SHOTS  per-slot live flags
// BEHAVIOUR
//  Reset: all slots inactive, x/y=0, cooldown=0, fire history=0, shotsDrawingRequest=0,
//   shotsRGB=8'hFF, drawnSlot=0. Reset while shots are in flight clears them immediately.
//  Per-slot state: active, x[10:0], y[10:0]. Global state: cooldown counter, fire_d, drawnSlot.
//  Fire: accepted when fire & ~fire_d & cooldown==0 & at least one slot is free.
//   - Allocates the lowest-index free slot at x=playerX+SPAWN_X_OFFSET.
//   - y=playerY-SHOT_H, clamped to 0 when playerY<SHOT_H.
//   - active=1 on the next edge; cooldown loads COOLDOWN_FRAMES.
//   - Pool full or cooldown!=0: the press is dropped and the cooldown is left unchanged.
//   - A held key fires once.
//  Movement, on startOfFrame for each active slot:
//   - if y<SPEED: active<=0.
//   - else: y<=y-SPEED.
//   - cooldown decrements, saturating at 0.
//  Draw: a slot hits when it is active, x<=pixelX<x+SHOT_W and y<=pixelY<y+SHOT_H.
//   - Bounds are computed 12 bits wide, with no wrap.
//   - Lowest-index hitting slot wins.
//   - Result is registered (latency 1 cycle), and drawnSlot records the winning index.
//  Collision: collision=1 clears active[drawnSlot] on the next edge. It is ignored unless
//   shotsDrawingRequest=1 in that same cycle.
//  Simultaneous events:
//   - fire + startOfFrame: the new shot spawns unmoved; other slots move; cooldown is loaded (not decremented).
//   - collision + startOfFrame on the same slot: the kill wins.
//   - A slot freed by collision/retire in cycle N is not allocatable until cycle N+1.
// TESTING
//  1 reset; playerX=100,playerY=400, fire 0->1 -> slot0 live at (114,392), shotsActive=0001;
//    pixel(115,395) -> request=1, RGB=FC one cycle later; pixel(118,395) -> request=0, RGB=FF.
//  2 fire held high 20 frames -> exactly one shot. Re-press at frame 5 -> ignored.
//    Re-press after 8 startOfFrame pulses -> slot1 allocated.
//  3 COOLDOWN_FRAMES=0, 5 presses -> shotsActive=1111; 5th dropped.
//    Kill slot2 then press -> slot2 reused.
//  4 slot at y=7, startOfFrame -> y=3; next startOfFrame -> inactive.
//    Fire with playerY=5 -> spawn y=0.
//  5 drawing slot2, collision=1 coincident with startOfFrame -> slot2 inactive; slots 0,1,3 move by 4.
//  6 async reset pulse mid-frame with 3 live shots -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/shots_pool.sv
// rtl/shots_pool.sv - fixed pool of player shots: spawn, per-frame movement, retire and pixel draw
module shots_pool #(
  parameter int NUM_SHOTS       = 4,
  parameter int SHOT_W          = 4,
  parameter int SHOT_H          = 8,
  parameter int SPEED           = 4,
  parameter int SPAWN_X_OFFSET  = 14,
  parameter int COOLDOWN_FRAMES = 8,
  parameter logic [7:0] SHOT_RGB = 8'hFC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 fire,
  input  logic [10:0]          playerX,
  input  logic [10:0]          playerY,
  input  logic [10:0]          pixelX,
  input  logic [10:0]          pixelY,
  input  logic                 collision,
  output logic                 shotsDrawingRequest,
  output logic [7:0]           shotsRGB,
  output logic [NUM_SHOTS-1:0] shotsActive
);

  localparam int SW = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam logic [10:0] SPEED11  = 11'(SPEED);
  localparam logic [10:0] SHOT_H11 = 11'(SHOT_H);
  localparam logic [10:0] OFFSET11 = 11'(SPAWN_X_OFFSET);
  localparam logic [11:0] SHOT_W12 = 12'(SHOT_W);
  localparam logic [11:0] SHOT_H12 = 12'(SHOT_H);
  localparam logic [7:0]  COOL8    = 8'(COOLDOWN_FRAMES);

  logic [NUM_SHOTS-1:0] active;
  logic [10:0]          pos_x [NUM_SHOTS];
  logic [10:0]          pos_y [NUM_SHOTS];
  logic [7:0]           cooldown;
  logic                 fire_d;
  logic [SW-1:0]        drawn_slot;

  logic                 has_free;
  logic [SW-1:0]        free_slot;
  logic                 hit_any;
  logic [SW-1:0]        hit_slot;
  logic                 accept;
  logic                 kill;
  logic [10:0]          spawn_y;

  // Lowest-index free slot and lowest-index slot covering the current pixel
  always_comb begin
    has_free  = 1'b0;
    free_slot = '0;
    hit_any   = 1'b0;
    hit_slot  = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        has_free  = 1'b1;
        free_slot = SW'(i);
      end
      if (active[i] &&
          ({1'b0, pixelX} >= {1'b0, pos_x[i]}) && ({1'b0, pixelX} < ({1'b0, pos_x[i]} + SHOT_W12)) &&
          ({1'b0, pixelY} >= {1'b0, pos_y[i]}) && ({1'b0, pixelY} < ({1'b0, pos_y[i]} + SHOT_H12))) begin
        hit_any  = 1'b1;
        hit_slot = SW'(i);
      end
    end
  end

  assign accept  = fire & ~fire_d & (cooldown == 8'd0) & has_free;
  assign kill    = collision & shotsDrawingRequest;
  assign spawn_y = (playerY < SHOT_H11) ? 11'd0 : (playerY - SHOT_H11);

  // Per-slot spawn, kill-by-collision and upward movement with top-edge retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (accept && (free_slot == SW'(i))) begin
          active[i] <= 1'b1;
          pos_x[i]  <= playerX + OFFSET11;
          pos_y[i]  <= spawn_y;
        end else if (active[i]) begin
          if (kill && (drawn_slot == SW'(i))) begin
            active[i] <= 1'b0;
          end else if (startOfFrame) begin
            if (pos_y[i] < SPEED11) active[i] <= 1'b0;
            else                    pos_y[i]  <= pos_y[i] - SPEED11;
          end
        end
      end
    end
  end

  // Fire edge history and cooldown: load on accepted fire, else count frames down to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_d   <= 1'b0;
      cooldown <= 8'd0;
    end else begin
      fire_d <= fire;
      if (accept)                                cooldown <= COOL8;
      else if (startOfFrame && cooldown != 8'd0) cooldown <= cooldown - 8'd1;
    end
  end

  // Registered draw result; drawn_slot names the shot a collision next cycle refers to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shotsDrawingRequest <= 1'b0;
      shotsRGB            <= 8'hFF;
      drawn_slot          <= '0;
    end else begin
      shotsDrawingRequest <= hit_any;
      shotsRGB            <= hit_any ? SHOT_RGB : 8'hFF;
      drawn_slot          <= hit_slot;
    end
  end

  assign shotsActive = active;

endmodule
